// File: rtl/jtcps1_gfx_resp.sv
// Single-line (64-bit) response cache between the CPS1 tilemap engine and a 32-bit burst backend.
// Define JTCPS1_GFX_CACHE_EN to keep the fetched line across requests; otherwise every new request refills.
module jtcps1_gfx_resp #(
    parameter int AW = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rom_cs,
    input  logic [19:0]   rom_addr,
    input  logic          rom_half,
    output logic [31:0]   rom_data,
    output logic          rom_ok,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic          mem_dst,
    input  logic [31:0]   mem_data
);

    typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

    state_t      state;
    logic [31:0] line0, line1;
    logic [19:0] tag;
    logic [19:0] last_addr;
    logic        last_half;
    logic        ok_r;
    logic        hit;
    logic        wr0, wr1;

`ifdef JTCPS1_GFX_CACHE_EN
    logic valid;

    assign hit = rom_cs && valid && (rom_addr == tag) && (state == IDLE);
`else
    logic        prev_cs;
    logic [19:0] prev_addr;
    logic        pend;
    logic        fresh;

    // A new request (rising rom_cs or a new address) must always go to the backend,
    // even if it shows up while a fill is still running.
    assign fresh = rom_cs && (!prev_cs || (rom_addr != prev_addr));
    assign hit   = rom_cs && !fresh && !pend && (rom_addr == tag) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_cs   <= 1'b0;
            prev_addr <= '0;
            pend      <= 1'b0;
        end else begin
            prev_cs   <= rom_cs;
            prev_addr <= rom_addr;
            pend      <= (state == IDLE) ? 1'b0 : (pend | fresh);
        end
    end
`endif

    // rom_data is only trusted while the inputs still match the pair that produced it
    assign rom_ok = ok_r && rom_cs && (rom_addr == last_addr) && (rom_half == last_half);

    assign wr0 = mem_dst && ((state == BEAT0) || ((state == REQ) && mem_ack));
    assign wr1 = mem_dst && (state == BEAT1);

    always_ff @(posedge clk) begin
        if (wr0) line0 <= mem_data;
        if (wr1) line1 <= mem_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
`ifdef JTCPS1_GFX_CACHE_EN
            valid     <= 1'b0;
`endif
            tag       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            ok_r      <= 1'b0;
            rom_data  <= '0;
            last_addr <= '0;
            last_half <= 1'b0;
        end else begin
            ok_r <= hit;
            if (hit) begin
                rom_data  <= rom_half ? line1 : line0;
                last_addr <= rom_addr;
                last_half <= rom_half;
            end
            case (state)
                IDLE: begin
                    if (rom_cs && !hit) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= AW'({rom_addr, 1'b0});
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
`ifdef JTCPS1_GFX_CACHE_EN
                        valid   <= 1'b0;
`endif
                        // data arriving with the ack is the first beat
                        state   <= mem_dst ? BEAT1 : BEAT0;
                    end
                end
                BEAT0: begin
                    if (mem_dst) state <= BEAT1;
                end
                BEAT1: begin
                    if (mem_dst) begin
                        state <= IDLE;
                        tag   <= mem_addr[20:1];
`ifdef JTCPS1_GFX_CACHE_EN
                        valid <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcps1_gfx_resp.sv
// Scenario bench for jtcps1_gfx_resp: expected backend addresses and rom_data words are queued
// when stimulus is driven and popped when the DUT presents a request or a valid rom_ok.
module tb_jtcps1_gfx_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_cs;
    logic [19:0] rom_addr;
    logic        rom_half;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic        mem_ack;
    logic        mem_dst;
    logic [31:0] mem_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [20:0] addr_q[$];
    logic [31:0] data_q[$];
    logic [20:0] exp_a;
    logic [31:0] exp_d;
    bit          got;

    always #5 clk = ~clk;

    jtcps1_gfx_resp #(.AW(21)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_half (rom_half),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_dst  (mem_dst),
        .mem_data (mem_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req === 1'b1) found = 1'b1;
            else tick();
        end
    endtask

    task automatic do_ack;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic beats(input logic [31:0] d0, input logic [31:0] d1);
        mem_dst  = 1'b1;
        mem_data = d0;
        tick();
        mem_data = d1;
        tick();
        mem_dst  = 1'b0;
        mem_data = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rom_cs = 1'b1; rom_addr = 20'h00010; rom_half = 1'b1;
        mem_ack = 1'b0; mem_dst = 1'b0; mem_data = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (rom_ok !== 1'b0) begin
                n_fail++; $display("FAIL reset_rom_ok: got %b expected 0", rom_ok);
            end
        end
        n_chk++;
        if (mem_req !== 1'b0 || mem_addr !== 21'h0 || rom_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: mem_req=%b mem_addr=%h rom_data=%h expected 0/0/0", mem_req, mem_addr, rom_data);
        end
        addr_q.push_back(21'h00020);
        rst_n = 1'b1;
        tick();
        exp_a = addr_q.pop_front();
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== exp_a || rom_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_req: mem_req=%b mem_addr=%h rom_ok=%b expected 1/%h/0", mem_req, mem_addr, rom_ok, exp_a);
        end
    endtask

    task automatic test_miss_fill;
        data_q.push_back(32'h5555FFFF);
        do_ack();
        n_chk++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL miss_req_drop: got %b expected 0", mem_req);
        end
        beats(32'hAAAA0000, 32'h5555FFFF);
        n_chk++;
        if (rom_ok !== 1'b0) begin
            n_fail++; $display("FAIL miss_ok_early: got %b expected 0", rom_ok);
        end
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (rom_ok !== 1'b1 || rom_data !== exp_d) begin
            n_fail++; $display("FAIL miss_data: rom_ok=%b rom_data=%h expected 1/%h", rom_ok, rom_data, exp_d);
        end
    endtask

    task automatic test_hit;
        data_q.push_back(32'hAAAA0000);
        rom_half = 1'b0;
        #1;
        n_chk++;
        if (rom_ok !== 1'b0) begin
            n_fail++; $display("FAIL hit_ok_gap: got %b expected 0", rom_ok);
        end
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (rom_ok !== 1'b1 || rom_data !== exp_d || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_data: rom_ok=%b rom_data=%h mem_req=%b expected 1/%h/0", rom_ok, rom_data, mem_req, exp_d);
        end
        repeat (3) tick();
        n_chk++;
        if (mem_req !== 1'b0 || rom_ok !== 1'b1) begin
            n_fail++; $display("FAIL hit_steady: mem_req=%b rom_ok=%b expected 0/1", mem_req, rom_ok);
        end
    endtask

    task automatic test_reset_mid_fill;
        rom_addr = 20'h00030; rom_half = 1'b1;
        addr_q.push_back(21'h00060);
        addr_q.push_back(21'h00060);
        wait_req(got);
        exp_a = addr_q.pop_front();
        n_chk++;
        if (!got || mem_addr !== exp_a) begin
            n_fail++; $display("FAIL rmf_first_req: got_req=%b mem_addr=%h expected 1/%h", got, mem_addr, exp_a);
        end
        do_ack();
        mem_dst = 1'b1; mem_data = 32'h0BAD0000;
        tick();
        mem_dst = 1'b0;
        rst_n = 1'b0;
        tick();
        n_chk++;
        if (mem_req !== 1'b0 || rom_ok !== 1'b0) begin
            n_fail++; $display("FAIL rmf_in_reset: mem_req=%b rom_ok=%b expected 0/0", mem_req, rom_ok);
        end
        rst_n = 1'b1; mem_dst = 1'b1; mem_data = 32'hDEADBEEF;
        tick();
        exp_a = addr_q.pop_front();
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== exp_a) begin
            n_fail++; $display("FAIL rmf_rerequest: mem_req=%b mem_addr=%h expected 1/%h", mem_req, mem_addr, exp_a);
        end
        tick();
        mem_dst = 1'b0; mem_data = '0;
        data_q.push_back(32'h33334444);
        data_q.push_back(32'h11112222);
        do_ack();
        beats(32'h11112222, 32'h33334444);
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (rom_ok !== 1'b1 || rom_data !== exp_d) begin
            n_fail++; $display("FAIL rmf_hi: rom_ok=%b rom_data=%h expected 1/%h", rom_ok, rom_data, exp_d);
        end
        rom_half = 1'b0;
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (rom_ok !== 1'b1 || rom_data !== exp_d) begin
            n_fail++; $display("FAIL rmf_lo: rom_ok=%b rom_data=%h expected 1/%h", rom_ok, rom_data, exp_d);
        end
    endtask

    task automatic test_addr_change;
        rom_addr = 20'h00010; rom_half = 1'b0;
        addr_q.push_back(21'h00020);
        addr_q.push_back(21'h00022);
        wait_req(got);
        exp_a = addr_q.pop_front();
        n_chk++;
        if (!got || mem_addr !== exp_a) begin
            n_fail++; $display("FAIL chg_first_req: got_req=%b mem_addr=%h expected 1/%h", got, mem_addr, exp_a);
        end
        do_ack();
        rom_addr = 20'h00011;
        beats(32'hAAAA0000, 32'h5555FFFF);
        n_chk++;
        if (rom_ok !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL chg_after_fill: rom_ok=%b mem_req=%b expected 0/0", rom_ok, mem_req);
        end
        tick();
        exp_a = addr_q.pop_front();
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== exp_a || rom_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_second_req: mem_req=%b mem_addr=%h rom_ok=%b expected 1/%h/0", mem_req, mem_addr, rom_ok, exp_a);
        end
        data_q.push_back(32'hCAFE0000);
        do_ack();
        beats(32'hCAFE0000, 32'hBEEF0001);
        n_chk++;
        if (rom_ok !== 1'b0) begin
            n_fail++; $display("FAIL chg_ok_early: got %b expected 0", rom_ok);
        end
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (rom_ok !== 1'b1 || rom_data !== exp_d) begin
            n_fail++; $display("FAIL chg_data: rom_ok=%b rom_data=%h expected 1/%h", rom_ok, rom_data, exp_d);
        end
    endtask

    task automatic test_ack_dst_coincide;
        rom_addr = 20'h00040; rom_half = 1'b0;
        addr_q.push_back(21'h00080);
        data_q.push_back(32'h12345678);
        data_q.push_back(32'h9ABCDEF0);
        wait_req(got);
        exp_a = addr_q.pop_front();
        n_chk++;
        if (!got || mem_addr !== exp_a) begin
            n_fail++; $display("FAIL coin_req: got_req=%b mem_addr=%h expected 1/%h", got, mem_addr, exp_a);
        end
        mem_ack = 1'b1; mem_dst = 1'b1; mem_data = 32'h12345678;
        tick();
        mem_ack = 1'b0; mem_data = 32'h9ABCDEF0;
        tick();
        mem_dst = 1'b0; mem_data = '0;
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (rom_ok !== 1'b1 || rom_data !== exp_d) begin
            n_fail++; $display("FAIL coin_beat0: rom_ok=%b rom_data=%h expected 1/%h", rom_ok, rom_data, exp_d);
        end
        rom_half = 1'b1;
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (rom_ok !== 1'b1 || rom_data !== exp_d) begin
            n_fail++; $display("FAIL coin_beat1: rom_ok=%b rom_data=%h expected 1/%h", rom_ok, rom_data, exp_d);
        end
    endtask

    task automatic test_rerequest;
        rom_cs = 1'b0;
        #1;
        n_chk++;
        if (rom_ok !== 1'b0) begin
            n_fail++; $display("FAIL rereq_cs_low: got %b expected 0", rom_ok);
        end
        tick();
        rom_cs = 1'b1;
`ifdef JTCPS1_GFX_CACHE_EN
        data_q.push_back(32'h9ABCDEF0);
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (mem_req !== 1'b0 || rom_ok !== 1'b1 || rom_data !== exp_d) begin
            n_fail++;
            $display("FAIL rereq_cached: mem_req=%b rom_ok=%b rom_data=%h expected 0/1/%h", mem_req, rom_ok, rom_data, exp_d);
        end
`else
        addr_q.push_back(21'h00080);
        data_q.push_back(32'h88880001);
        wait_req(got);
        exp_a = addr_q.pop_front();
        n_chk++;
        if (!got || mem_addr !== exp_a) begin
            n_fail++; $display("FAIL rereq_burst: got_req=%b mem_addr=%h expected 1/%h", got, mem_addr, exp_a);
        end
        do_ack();
        beats(32'h77770000, 32'h88880001);
        tick();
        exp_d = data_q.pop_front();
        n_chk++;
        if (rom_ok !== 1'b1 || rom_data !== exp_d) begin
            n_fail++; $display("FAIL rereq_data: rom_ok=%b rom_data=%h expected 1/%h", rom_ok, rom_data, exp_d);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_reset_mid_fill();
        test_addr_change();
        test_ack_dst_coincide();
        test_rerequest();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/jtcps1_gfx_resp.md
JTCPS1_GFX_RESP -- requirements
Module: jtcps1_gfx_resp

Interface
REQ-001 SHALL have parameter AW, default 21, the backend word-address width (a 32-bit word address).
REQ-002 SHALL have port clk  in  1  single system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port rom_cs  in  1  tile fetch request from the tilemap engine.
REQ-005 SHALL have port rom_addr  in  20  64-bit line address.
REQ-006 SHALL have port rom_half  in  1  selects the 32-bit half of the line (0 = low word, 1 = high word).
REQ-007 SHALL have port rom_data  out  32  requested half-word.
REQ-008 SHALL have port rom_ok  out  1  rom_data valid for the current rom_addr/rom_half.
REQ-009 SHALL have port mem_req  out  1  backend read request, held until mem_ack.
REQ-010 SHALL have port mem_addr  out  AW  backend word address, {rom_addr, 1'b0}.
REQ-011 SHALL have port mem_ack  in  1  backend accepted the request (one-cycle pulse).
REQ-012 SHALL have port mem_dst  in  1  backend data beat strobe (one cycle per beat, two beats per burst).
REQ-013 SHALL have port mem_data  in  32  backend data, valid with mem_dst.

Function
REQ-014 SHALL implement states IDLE, REQ, BEAT0, BEAT1.
- IDLE -> REQ on rom_cs with a miss.
- REQ -> BEAT0 on mem_ack.
- BEAT0 -> BEAT1 on the first mem_dst.
- BEAT1 -> IDLE on the second mem_dst.
REQ-015 SHALL hold one 64-bit line buffer plus a 20-bit tag and a valid flag.
REQ-016 SHALL count a hit when rom_cs=1, valid=1, rom_addr==tag and state==IDLE; anything else with rom_cs=1 is a miss.
REQ-017 SHALL, on a hit, register rom_data=line[rom_half] and raise rom_ok on the next cycle (latency 1).
REQ-018 SHALL, on a miss, assert mem_req and latch mem_addr={rom_addr,0} on the cycle after the miss is detected; mem_addr is stable until mem_ack.
REQ-019 SHALL, during a fill, write the first beat to line[0] and the second to line[1], clear valid at mem_ack, and set tag and valid at the second beat.
REQ-020 SHALL treat the fill completion as a hit on the following IDLE cycle, so rom_ok rises 2 cycles after the second mem_dst.
REQ-021 SHALL force rom_ok low combinationally in any cycle where rom_cs=0, or rom_addr/rom_half differs from the pair that produced the registered rom_data.
REQ-022 SHALL not abort a fill once mem_req is asserted; rom_cs dropping or rom_addr changing mid-fill still completes and caches the line.
- After completion, a changed address is a fresh miss.
REQ-023 SHALL, when only rom_half changes while rom_addr still hits, update rom_data with no backend access; rom_ok is low for exactly 1 cycle.
REQ-024 SHALL ignore mem_dst outside BEAT0/BEAT1 and mem_ack outside REQ.
REQ-025 SHALL, if mem_ack and mem_dst coincide in REQ, take the ack and capture that data as beat 0 (go directly to BEAT1).

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set state=IDLE, valid=0, tag=0, mem_req=0, mem_addr=0, rom_ok=0, rom_data=0.
REQ-027 SHALL, on reset mid-fill, drop mem_req immediately and discard any beats of the abandoned burst that arrive afterwards.

Configuration
REQ-028 SHALL honour macro JTCPS1_GFX_CACHE_EN.
- Defined: line caching as specified above.
- Undefined: the hit check is disabled (valid is never consulted), so every new rom_cs assertion or rom_addr change triggers a backend fill; rom_half changes still serve from the current line.

Verification
REQ-029 Reset with rom_cs=1, rom_addr=20'h00010 -> after rst_n rises, mem_req=1 next cycle with mem_addr=21'h00020; rom_ok=0 throughout reset.
REQ-030 Miss fill: mem_ack, then beats 32'hAAAA0000 and 32'h5555FFFF with rom_half=1 -> rom_ok=1, rom_data=32'h5555FFFF, 2 cycles after beat 2.
REQ-031 Hit: same rom_addr, toggle rom_half to 0 -> no mem_req, rom_ok low 1 cycle, then rom_data=32'hAAAA0000.
REQ-032 Change rom_addr to 20'h00011 between mem_ack and beat 0 -> fill of 0x00010 completes, then a new mem_req with mem_addr=21'h00022; rom_ok stays 0 until the new line arrives.
REQ-033 Assert rst_n=0 during BEAT1, then release -> mem_req=0, a stray mem_dst is ignored, and the same rom_addr re-requests (valid=0).
REQ-034 Without JTCPS1_GFX_CACHE_EN: drop rom_cs, re-request the same rom_addr -> a second backend burst occurs.
